adder_tree_pipe: RTL

Parametrised, pipelined signed adder tree that reduces NUM_IN window products to one sum per cycle, replacing the fixed per-level Laplacian adder stages of the convolution datapath. Sits between the multiply/product stage and the output writer. Adds valid/ready flow control with global stall, zero-padding for non-power-of-2 windows, an optional absolute-value mode for edge magnitude, and output saturation.

---
 rtl/conv_pkg.sv | 39 +++
 rtl/adder_tree_pipe_if.sv | 25 ++
 rtl/adder_tree_level.sv | 49 ++++
 rtl/adder_tree_pipe.sv | 98 +++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared helpers for the convolution datapath: width derivation plus signed
// magnitude and saturation functions reused by the convolution blocks.
package conv_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int full_w(input int in_w, input int num_in);
        return in_w + clog2(num_in);
    endfunction

    // 64-bit working width so negating the most negative sum cannot wrap.
    function automatic logic signed [63:0] abs_val(input logic signed [63:0] v, input logic en);
        return (en && (v < 0)) ? -v : v;
    endfunction

    function automatic logic signed [63:0] sat_max(input int res_w);
        return (64'sd1 <<< (res_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int res_w);
        return -sat_max(res_w) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_val(input logic signed [63:0] v, input int res_w);
        if (v > sat_max(res_w)) return sat_max(res_w);
        if (v < sat_min(res_w)) return sat_min(res_w);
        return v;
    endfunction

    function automatic logic sat_flag(input logic signed [63:0] v, input int res_w);
        return (v > sat_max(res_w)) || (v < sat_min(res_w));
    endfunction

endpackage

// File: rtl/adder_tree_pipe_if.sv
// Operand/result bundle of the pipelined adder tree, with valid/ready on both sides.
interface adder_tree_pipe_if #(
    parameter int NUM_IN = 8,
    parameter int IN_W   = 5,
    parameter int RES_W  = IN_W + conv_pkg::clog2(NUM_IN)
);
    logic [NUM_IN*IN_W-1:0] in_data;
    logic                   in_abs;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [RES_W-1:0] out_data;
    logic                   out_sat;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_data, in_abs, in_valid, out_ready,
        input  in_ready, out_data, out_sat, out_valid
    );

    modport slave (
        input  in_data, in_abs, in_valid, out_ready,
        output in_ready, out_data, out_sat, out_valid
    );
endinterface

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: adjacent pairs summed one bit wider,
// an odd trailing element passes through sign-extended; valid/abs ride along.
module adder_tree_level #(
    parameter int N_IN  = 2,
    parameter int W     = 5,
    localparam int N_OUT = (N_IN + 1) / 2,
    localparam int PW    = 2 * N_OUT * W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N_IN*W-1:0]      in_data,
    input  logic                   in_vld,
    input  logic                   in_abs,
    output logic [N_OUT*(W+1)-1:0] out_data,
    output logic                   out_vld,
    output logic                   out_abs
);

    function automatic logic signed [W:0] sext(input logic [W-1:0] v);
        return {v[W-1], v};
    endfunction

    logic [PW-1:0]          ext_p0;
    logic [N_OUT*(W+1)-1:0] sum_p0;

    // Zero-extending to an even count makes the odd element add with zero.
    assign ext_p0 = PW'(in_data);

    always_comb begin
        sum_p0 = '0;
        for (int i = 0; i < N_OUT; i++)
            sum_p0[i*(W+1) +: W+1] = sext(ext_p0[2*i*W +: W]) + sext(ext_p0[(2*i+1)*W +: W]);
    end

    // ---- level register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_vld  <= 1'b0;
            out_abs  <= 1'b0;
        end else if (en) begin
            out_data <= sum_p0;
            out_vld  <= in_vld;
            out_abs  <= in_abs;
        end
    end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree: NUM_IN operands reduced over clog2(NUM_IN)
// registered levels, then a registered abs/saturate stage, under a global stall.
module adder_tree_pipe
    import conv_pkg::*;
#(
    parameter int NUM_IN = 8,
    parameter int IN_W   = 5,
    parameter int RES_W  = IN_W + clog2(NUM_IN)
) (
    input logic             clk,
    input logic             rst,
    adder_tree_pipe_if.slave bus
);

    localparam int L      = clog2(NUM_IN);
    localparam int NP     = 1 << L;
    localparam int FULL_W = full_w(IN_W, NUM_IN);

    logic adv;
    assign adv          = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = adv;

    // Bubbles enter as zero data so idle output cycles read back as zero.
    logic [NP*IN_W-1:0] pad_p0;
    logic               vld_p0;
    logic               abs_p0;

    always_comb begin
        pad_p0 = bus.in_valid ? (NP*IN_W)'(bus.in_data) : '0;
        vld_p0 = bus.in_valid;
        abs_p0 = bus.in_valid & bus.in_abs;
    end

    for (genvar g = 0; g < L; g++) begin : lvl
        localparam int NI = NP >> g;
        localparam int WI = IN_W + g;

        logic [NI*WI-1:0]           din;
        logic                       vi;
        logic                       ai;
        logic [((NI+1)/2)*(WI+1)-1:0] dout;
        logic                       vo;
        logic                       ao;

        if (g == 0) begin : g_first
            assign din = pad_p0;
            assign vi  = vld_p0;
            assign ai  = abs_p0;
        end else begin : g_next
            assign din = lvl[g-1].dout;
            assign vi  = lvl[g-1].vo;
            assign ai  = lvl[g-1].ao;
        end

        adder_tree_level #(.N_IN(NI), .W(WI)) u_level (
            .clk      (clk),
            .rst      (rst),
            .en       (adv),
            .in_data  (din),
            .in_vld   (vi),
            .in_abs   (ai),
            .out_data (dout),
            .out_vld  (vo),
            .out_abs  (ao)
        );
    end

    logic signed [FULL_W-1:0] sum_pl;
    logic                     vld_pl;
    logic                     abs_pl;
    logic signed [63:0]       mag_pl;
    logic signed [RES_W-1:0]  res_pl;
    logic                     sat_pl;

    assign sum_pl = $signed(lvl[L-1].dout);
    assign vld_pl = lvl[L-1].vo;
    assign abs_pl = lvl[L-1].ao;

    always_comb begin
        mag_pl = abs_val(64'(sum_pl), abs_pl);
        res_pl = RES_W'(sat_val(mag_pl, RES_W));
        sat_pl = sat_flag(mag_pl, RES_W);
    end

    // ---- post stage register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (adv) begin
            bus.out_data  <= res_pl;
            bus.out_sat   <= sat_pl;
            bus.out_valid <= vld_pl;
        end
    end

endmodule
